// File: rtl/axi_rd_mem_responder_pkg.sv
// Shared encodings for the read-only AXI memory responder:
// burst types, FSM states and the response code.
package axi_rd_mem_responder_pkg;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [1:0] RRESP_OKAY  = 2'b00;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BURST = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  // WRAP bursts are only honoured for 2, 4, 8 or 16 beats.
  function automatic logic wrap_len_ok(input logic [7:0] len);
    return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
  endfunction

endpackage

// File: rtl/axi_rd_mem_responder_fifo.sv
// Two-entry synchronous FIFO holding {last, data} for the R channel.
// The caller never pushes into a full FIFO nor pops an empty one.
module axi_rd_mem_responder_fifo #(
  parameter int W = 65
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic [1:0]   count
);

  logic [W-1:0] mem [0:1];
  logic         wr_ptr;
  logic         rd_ptr;

  // Storage, pointers and occupancy; reset clears contents so the head reads zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/axi_rd_mem_responder.sv
// AXI4 read-only responder in front of a 64-bit single-port memory.
// One burst outstanding at a time. Reads are issued against a two-slot
// credit (FIFO entries plus the read whose data is still on Q), so the
// R channel can stream one beat per cycle while RREADY stays high.
//
// Handshakes: a transfer happens on a rising ACLK edge where VALID and
// READY are both high; a VALID source holds its payload stable until that
// edge, and READY may be asserted independently of VALID.
module axi_rd_mem_responder
  import axi_rd_mem_responder_pkg::*;
#(
  parameter int AXI4_ADDRESS_WIDTH = 32,
  parameter int AXI4_RDATA_WIDTH   = 64,
  parameter int AXI4_ID_WIDTH      = 7,
  parameter int AXI4_USER_WIDTH    = 4,
  parameter int MEM_ADDR_WIDTH     = 20
) (
  input  logic                          ACLK,
  input  logic                          ARESET,

  input  logic                          ARVALID_i,
  input  logic [AXI4_ADDRESS_WIDTH-1:0] ARADDR_i,
  input  logic [7:0]                    ARLEN_i,
  input  logic [2:0]                    ARSIZE_i,
  input  logic [1:0]                    ARBURST_i,
  input  logic [AXI4_ID_WIDTH-1:0]      ARID_i,
  input  logic [AXI4_USER_WIDTH-1:0]    ARUSER_i,
  output logic                          ARREADY_o,

  output logic                          RVALID_o,
  output logic [AXI4_RDATA_WIDTH-1:0]   RDATA_o,
  output logic [1:0]                    RRESP_o,
  output logic                          RLAST_o,
  output logic [AXI4_ID_WIDTH-1:0]      RID_o,
  output logic [AXI4_USER_WIDTH-1:0]    RUSER_o,
  input  logic                          RREADY_i,

  output logic                          CEN,
  output logic [MEM_ADDR_WIDTH-1:0]     A,
  input  logic [AXI4_RDATA_WIDTH-1:0]   Q
);

  state_t                        state;
  logic                          arready_q;
  logic [AXI4_ADDRESS_WIDTH-1:0] cur_addr;
  logic [7:0]                    len_q;
  logic [1:0]                    size_q;
  logic [1:0]                    mode_q;
  logic [8:0]                    beats_left;
  logic [AXI4_ID_WIDTH-1:0]      id_q;
  logic [AXI4_USER_WIDTH-1:0]    user_q;
  logic                          in_flight;
  logic                          in_flight_last;

  logic [AXI4_RDATA_WIDTH:0]     fifo_head;
  logic [1:0]                    fifo_count;
  logic                          rvalid;
  logic                          pop;
  logic [2:0]                    occupancy;
  logic                          issue;
  logic                          issue_last;

  logic [AXI4_ADDRESS_WIDTH-1:0] step;
  logic [AXI4_ADDRESS_WIDTH-1:0] wrap_mask;
  logic [AXI4_ADDRESS_WIDTH-1:0] incr_addr;
  logic [AXI4_ADDRESS_WIDTH-1:0] next_addr;

  // Read issue: occupancy counts a beat leaving this cycle, so a stream can
  // keep one read in flight and one beat buffered indefinitely.
  always_comb begin
    rvalid     = (fifo_count != 2'd0);
    pop        = rvalid & RREADY_i;
    occupancy  = {1'b0, fifo_count} + {2'b00, in_flight} - {2'b00, pop};
    issue      = (state == ST_BURST) && (beats_left != 9'd0) && (occupancy < 3'd2);
    issue_last = (beats_left == 9'd1);
  end

  // Next burst address; the mode was already resolved when the AR was latched.
  always_comb begin
    step      = AXI4_ADDRESS_WIDTH'(1) << size_q;
    wrap_mask = (AXI4_ADDRESS_WIDTH'({1'b0, len_q} + 9'd1) << size_q)
                - AXI4_ADDRESS_WIDTH'(1);
    incr_addr = cur_addr + step;
    next_addr = incr_addr;
    case (mode_q)
      BURST_FIXED: next_addr = cur_addr;
      BURST_WRAP:  next_addr = (cur_addr & ~wrap_mask) | (incr_addr & wrap_mask);
      default:     next_addr = incr_addr;
    endcase
  end

  // Control FSM: accept AR, issue reads, wait for the RLAST handshake.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state          <= ST_IDLE;
      arready_q      <= 1'b0;
      cur_addr       <= '0;
      len_q          <= 8'd0;
      size_q         <= 2'd0;
      mode_q         <= BURST_INCR;
      beats_left     <= 9'd0;
      id_q           <= '0;
      user_q         <= '0;
      in_flight      <= 1'b0;
      in_flight_last <= 1'b0;
    end else begin
      in_flight      <= issue;
      in_flight_last <= issue & issue_last;
      case (state)
        ST_IDLE: begin
          if (ARVALID_i && arready_q) begin
            cur_addr   <= ARADDR_i;
            len_q      <= ARLEN_i;
            size_q     <= (ARSIZE_i > 3'd3) ? 2'd3 : ARSIZE_i[1:0];
            if (ARBURST_i == BURST_FIXED) begin
              mode_q <= BURST_FIXED;
            end else if (ARBURST_i == BURST_WRAP && wrap_len_ok(ARLEN_i)) begin
              mode_q <= BURST_WRAP;
            end else begin
              mode_q <= BURST_INCR;
            end
            beats_left <= {1'b0, ARLEN_i} + 9'd1;
            id_q       <= ARID_i;
            user_q     <= ARUSER_i;
            arready_q  <= 1'b0;
            state      <= ST_BURST;
          end else begin
            arready_q <= 1'b1;
          end
        end
        ST_BURST: begin
          if (issue) begin
            cur_addr   <= next_addr;
            beats_left <= beats_left - 9'd1;
            if (issue_last) begin
              state <= ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          if (pop && fifo_head[AXI4_RDATA_WIDTH]) begin
            state     <= ST_IDLE;
            arready_q <= 1'b1;
          end
        end
        default: begin
          state     <= ST_IDLE;
          arready_q <= 1'b0;
        end
      endcase
    end
  end

  axi_rd_mem_responder_fifo #(
    .W (AXI4_RDATA_WIDTH + 1)
  ) u_fifo (
    .clk       (ACLK),
    .rst       (ARESET),
    .push      (in_flight),
    .push_data ({in_flight_last, Q}),
    .pop       (pop),
    .head      (fifo_head),
    .count     (fifo_count)
  );

  assign ARREADY_o = arready_q;
  assign RVALID_o  = rvalid;
  assign RDATA_o   = fifo_head[AXI4_RDATA_WIDTH-1:0];
  assign RLAST_o   = fifo_head[AXI4_RDATA_WIDTH];
  assign RID_o     = id_q;
  assign RUSER_o   = user_q;
  assign RRESP_o   = RRESP_OKAY;
  assign CEN       = ~issue;
  assign A         = issue ? cur_addr[MEM_ADDR_WIDTH+2:3] : '0;

endmodule
